// File: rtl/fp_execute_stage4_pkg.sv
// Shared types and constants for the fourth FP execute stage.
// Holds the decoded-instruction layout and the lane count the pipeline is built for.
package fp_execute_stage4_pkg;

    localparam int VECTOR_LANES = 16;
    localparam logic [7:0] FP_EXP_MAX = 8'hff;

    typedef logic [31:0] scalar_t;
    typedef logic [1:0]  thread_idx_t;
    typedef logic [1:0]  subcycle_t;

    typedef enum logic [3:0] {
        OP_FADD = 4'd0,
        OP_FSUB = 4'd1,
        OP_FMUL = 4'd2,
        OP_ITOF = 4'd3,
        OP_FTOI = 4'd4
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [4:0]  dest_reg;
        logic        has_dest;
        scalar_t     immediate;
    } decoded_instruction_t;

endpackage

// File: rtl/fp_execute_stage4_if.sv
// Stage-3 to stage-4 input bundle and stage-4 to stage-5 output bundle.
// Handshake: fx3_instruction_valid qualifies all fx3_* fields in the same cycle; there is no ready, every cycle is accepted.
interface fp_execute_stage4_if #(parameter int LANES = 16);
    import fp_execute_stage4_pkg::*;

    logic                        fx3_instruction_valid;
    decoded_instruction_t        fx3_instruction;
    logic [LANES-1:0]            fx3_mask_value;
    thread_idx_t                 fx3_thread_idx;
    subcycle_t                   fx3_subcycle;
    logic [LANES-1:0]            fx3_result_is_inf;
    logic [LANES-1:0]            fx3_result_is_nan;
    logic [LANES-1:0][31:0]      fx3_add_significand;
    logic [LANES-1:0][7:0]       fx3_add_exponent;
    logic [LANES-1:0]            fx3_add_result_sign;
    logic [LANES-1:0][63:0]      fx3_significand_product;
    logic [LANES-1:0][7:0]       fx3_mul_exponent;
    logic [LANES-1:0]            fx3_mul_sign;

    logic                        fx4_instruction_valid;
    decoded_instruction_t        fx4_instruction;
    logic [LANES-1:0]            fx4_mask_value;
    thread_idx_t                 fx4_thread_idx;
    subcycle_t                   fx4_subcycle;
    logic [LANES-1:0]            fx4_result_is_inf;
    logic [LANES-1:0]            fx4_result_is_nan;
    logic [LANES-1:0]            fx4_result_is_zero;
    logic [LANES-1:0]            fx4_underflow;
    logic [LANES-1:0][31:0]      fx4_add_significand;
    logic [LANES-1:0][7:0]       fx4_add_exponent;
    logic [LANES-1:0]            fx4_add_result_sign;
    logic [LANES-1:0][31:0]      fx4_mul_significand;
    logic [LANES-1:0][7:0]       fx4_mul_exponent;
    logic [LANES-1:0]            fx4_mul_sticky;
    logic [LANES-1:0]            fx4_mul_sign;

    modport master (
        output fx3_instruction_valid, fx3_instruction, fx3_mask_value, fx3_thread_idx,
               fx3_subcycle, fx3_result_is_inf, fx3_result_is_nan, fx3_add_significand,
               fx3_add_exponent, fx3_add_result_sign, fx3_significand_product,
               fx3_mul_exponent, fx3_mul_sign,
        input  fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx,
               fx4_subcycle, fx4_result_is_inf, fx4_result_is_nan, fx4_result_is_zero,
               fx4_underflow, fx4_add_significand, fx4_add_exponent, fx4_add_result_sign,
               fx4_mul_significand, fx4_mul_exponent, fx4_mul_sticky, fx4_mul_sign
    );

    modport slave (
        input  fx3_instruction_valid, fx3_instruction, fx3_mask_value, fx3_thread_idx,
               fx3_subcycle, fx3_result_is_inf, fx3_result_is_nan, fx3_add_significand,
               fx3_add_exponent, fx3_add_result_sign, fx3_significand_product,
               fx3_mul_exponent, fx3_mul_sign,
        output fx4_instruction_valid, fx4_instruction, fx4_mask_value, fx4_thread_idx,
               fx4_subcycle, fx4_result_is_inf, fx4_result_is_nan, fx4_result_is_zero,
               fx4_underflow, fx4_add_significand, fx4_add_exponent, fx4_add_result_sign,
               fx4_mul_significand, fx4_mul_exponent, fx4_mul_sticky, fx4_mul_sign
    );

endinterface

// File: rtl/fp_execute_stage4_lzc.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 32.
module fp_lzc32 (
    input  logic [31:0] value_i,
    output logic [5:0]  count_o
);

    // Scan upward so the most significant set bit is the last to write.
    always_comb begin
        count_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value_i[i]) count_o = 6'(31 - i);
        end
    end

endmodule

// File: rtl/fp_execute_stage4.sv
// FP execute stage 4: normalizes the add/sub/itof sum and the multiply product, one-cycle latency.
// Only valid is reset; every other register loads every cycle, including while reset is high.
module fp_execute_stage4
    import fp_execute_stage4_pkg::*;
#(
    parameter int LANES = VECTOR_LANES
) (
    input  logic               clk,
    input  logic               reset,
    fp_execute_stage4_if.slave bus
);

    logic [LANES-1:0][5:0]  lzc;
    logic [LANES-1:0]       unused_prod_hi;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fp_lzc32 u_lzc (
            .value_i (bus.fx3_add_significand[l]),
            .count_o (lzc[l])
        );
        // A 24x24 product never reaches the upper 16 bits.
        assign unused_prod_hi[l] = |bus.fx3_significand_product[l][63:48];
    end

    logic [LANES-1:0][31:0] add_sig_d, add_sig_q, mul_sig_d, mul_sig_q;
    logic [LANES-1:0][7:0]  add_exp_d, add_exp_q, mul_exp_d, mul_exp_q;
    logic [LANES-1:0]       zero_d, zero_q, uf_d, uf_q, inf_d, inf_q;
    logic [LANES-1:0]       nan_d, nan_q, sticky_d, sticky_q;
    logic [LANES-1:0]       add_sign_q, mul_sign_q, mask_q;
    logic                   valid_q;
    decoded_instruction_t   instr_q;
    thread_idx_t            thread_q;
    subcycle_t              subcycle_q;

    logic                   is_mul, is_ftoi, add_path;
    logic signed [9:0]      add_e;
    logic [8:0]             mul_e;
    logic [63:0]            prod;

    // Flags are raised only by the path the opcode actually uses, so stale data
    // in the idle path never marks a result inf, zero or underflow.
    always_comb begin
        is_mul    = bus.fx3_instruction.alu_op == OP_FMUL;
        is_ftoi   = bus.fx3_instruction.alu_op == OP_FTOI;
        add_path  = !is_mul && !is_ftoi;
        add_e     = '0;
        mul_e     = '0;
        prod      = '0;
        add_sig_d = '0;
        add_exp_d = '0;
        mul_sig_d = '0;
        mul_exp_d = '0;
        zero_d    = '0;
        uf_d      = '0;
        sticky_d  = '0;
        inf_d     = bus.fx3_result_is_inf;
        nan_d     = bus.fx3_result_is_nan;
        for (int l = 0; l < LANES; l++) begin
            add_e = $signed({2'b00, bus.fx3_add_exponent[l]}) + 10'sd8
                    - $signed({4'b0000, lzc[l]});
            if (is_ftoi) begin
                add_sig_d[l] = bus.fx3_add_significand[l];
                add_exp_d[l] = 8'd0;
            end else if (bus.fx3_add_significand[l] == 32'd0) begin
                zero_d[l]    = add_path;
                add_sig_d[l] = 32'd0;
                add_exp_d[l] = 8'd0;
            end else if (add_e <= 10'sd0) begin
                uf_d[l]      = add_path;
                add_sig_d[l] = 32'd0;
                add_exp_d[l] = 8'd0;
            end else if (add_e >= 10'sd255) begin
                inf_d[l]     = inf_d[l] | add_path;
                add_sig_d[l] = bus.fx3_add_significand[l] << lzc[l];
                add_exp_d[l] = FP_EXP_MAX;
            end else begin
                add_sig_d[l] = bus.fx3_add_significand[l] << lzc[l];
                add_exp_d[l] = add_e[7:0];
            end

            prod = bus.fx3_significand_product[l];
            if (prod[47]) begin
                mul_sig_d[l] = prod[47:16];
                sticky_d[l]  = |prod[15:0];
                mul_e        = {1'b0, bus.fx3_mul_exponent[l]} + 9'd1;
            end else begin
                mul_sig_d[l] = prod[46:15];
                sticky_d[l]  = |prod[14:0];
                mul_e        = {1'b0, bus.fx3_mul_exponent[l]};
            end
            if (prod[47] && mul_e >= 9'd255) begin
                mul_exp_d[l] = FP_EXP_MAX;
                inf_d[l]     = inf_d[l] | is_mul;
            end else begin
                mul_exp_d[l] = mul_e[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= bus.fx3_instruction_valid;
    end

    always_ff @(posedge clk) begin
        instr_q    <= bus.fx3_instruction;
        mask_q     <= bus.fx3_mask_value;
        thread_q   <= bus.fx3_thread_idx;
        subcycle_q <= bus.fx3_subcycle;
        add_sign_q <= bus.fx3_add_result_sign;
        mul_sign_q <= bus.fx3_mul_sign;
        add_sig_q  <= add_sig_d;
        add_exp_q  <= add_exp_d;
        mul_sig_q  <= mul_sig_d;
        mul_exp_q  <= mul_exp_d;
        zero_q     <= zero_d;
        uf_q       <= uf_d;
        inf_q      <= inf_d;
        nan_q      <= nan_d;
        sticky_q   <= sticky_d;
    end

    assign bus.fx4_instruction_valid = valid_q;
    assign bus.fx4_instruction       = instr_q;
    assign bus.fx4_mask_value        = mask_q;
    assign bus.fx4_thread_idx        = thread_q;
    assign bus.fx4_subcycle          = subcycle_q;
    assign bus.fx4_result_is_inf     = inf_q;
    assign bus.fx4_result_is_nan     = nan_q;
    assign bus.fx4_result_is_zero    = zero_q;
    assign bus.fx4_underflow         = uf_q;
    assign bus.fx4_add_significand   = add_sig_q;
    assign bus.fx4_add_exponent      = add_exp_q;
    assign bus.fx4_add_result_sign   = add_sign_q;
    assign bus.fx4_mul_significand   = mul_sig_q;
    assign bus.fx4_mul_exponent      = mul_exp_q;
    assign bus.fx4_mul_sticky        = sticky_q;
    assign bus.fx4_mul_sign          = mul_sign_q;

endmodule

// File: tb/tb_fp_execute_stage4.sv
// Bench for fp_execute_stage4: hand-computed vectors on lane 0, reference model on the other lanes.
module tb_fp_execute_stage4;
  import fp_execute_stage4_pkg::*;

  localparam int LANES = VECTOR_LANES;

  typedef struct {
    logic [31:0] add_sig;
    logic [7:0]  add_exp;
    logic [63:0] prod;
    logic [7:0]  mul_exp;
    logic        inf;
    logic        nan;
    logic        add_sign;
    logic        mul_sign;
  } lane_in_t;

  typedef struct {
    logic [31:0] add_sig;
    logic [7:0]  add_exp;
    logic        zero;
    logic        uf;
    logic        inf;
    logic        nan;
    logic [31:0] mul_sig;
    logic [7:0]  mul_exp;
    logic        sticky;
  } lane_out_t;

  typedef struct {
    alu_op_t   op;
    lane_in_t  i;
    lane_out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_execute_stage4_if #(.LANES(LANES)) bus();

  fp_execute_stage4 #(.LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  lane_in_t             cur[LANES];
  vec_t                 vecs[$];
  decoded_instruction_t exp_instr;
  logic [LANES-1:0]     exp_mask;
  thread_idx_t          exp_thread;
  subcycle_t            exp_sub;
  alu_op_t              cur_op;
  bit                   seq_valid[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit                   seq_reset[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit                   seq_exp[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Normalizes by repeated single-bit shifts rather than a leading-zero count.
  function automatic lane_out_t model(input alu_op_t op, input lane_in_t i);
    lane_out_t o;
    logic [31:0] s;
    int sh;
    int e;
    bit add_path;
    add_path = (op != OP_FMUL) && (op != OP_FTOI);
    o.inf = i.inf; o.nan = i.nan; o.zero = 1'b0; o.uf = 1'b0;
    s = i.add_sig; sh = 0;
    while (sh < 32 && !s[31]) begin s = s << 1; sh++; end
    e = int'(i.add_exp) + 8 - sh;
    if (op == OP_FTOI) begin o.add_sig = i.add_sig; o.add_exp = 8'd0; end
    else if (i.add_sig == 32'd0) begin o.add_sig = 0; o.add_exp = 0; o.zero = add_path; end
    else if (e <= 0) begin o.add_sig = 0; o.add_exp = 0; o.uf = add_path; end
    else if (e >= 255) begin o.add_sig = s; o.add_exp = 8'hff; if (add_path) o.inf = 1'b1; end
    else begin o.add_sig = s; o.add_exp = 8'(e); end
    if (i.prod[47]) begin
      o.mul_sig = i.prod[47:16];
      o.sticky  = i.prod[15:0] != 16'd0;
      e = int'(i.mul_exp) + 1;
      if (e >= 255) begin o.mul_exp = 8'hff; if (op == OP_FMUL) o.inf = 1'b1; end
      else o.mul_exp = 8'(e);
    end else begin
      o.mul_sig = i.prod[46:15];
      o.sticky  = i.prod[14:0] != 15'd0;
      o.mul_exp = i.mul_exp;
    end
    return o;
  endfunction

  function automatic lane_in_t rand_lane();
    lane_in_t i;
    i.add_sig  = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 9) == 0) i.add_sig = 32'd0;
    i.add_exp  = 8'($urandom);
    i.prod     = {16'h0, 16'($urandom), 32'($urandom)};
    i.mul_exp  = 8'($urandom);
    i.inf      = $urandom_range(0, 7) == 0;
    i.nan      = $urandom_range(0, 7) == 0;
    i.add_sign = 1'($urandom);
    i.mul_sign = 1'($urandom);
    return i;
  endfunction

  function automatic vec_t mk(input alu_op_t op, input logic [31:0] as, input logic [7:0] ae,
                              input logic [63:0] p, input logic [7:0] me, input logic fi, input logic fn,
                              input logic [31:0] eas, input logic [7:0] eae, input logic ez, input logic eu,
                              input logic ei, input logic en, input logic [31:0] ems, input logic [7:0] eme,
                              input logic est);
    vec_t v;
    v.op = op;
    v.i  = '{add_sig: as, add_exp: ae, prod: p, mul_exp: me, inf: fi, nan: fn, add_sign: 1'b1, mul_sign: 1'b0};
    v.o  = '{add_sig: eas, add_exp: eae, zero: ez, uf: eu, inf: ei, nan: en, mul_sig: ems, mul_exp: eme, sticky: est};
    return v;
  endfunction

  task automatic drive(input logic valid, input alu_op_t op);
    cur_op     = op;
    exp_instr  = '{alu_op: op, dest_reg: 5'($urandom), has_dest: 1'($urandom), immediate: $urandom};
    exp_mask   = LANES'($urandom);
    exp_thread = thread_idx_t'($urandom);
    exp_sub    = subcycle_t'($urandom);
    bus.fx3_instruction_valid = valid;
    bus.fx3_instruction       = exp_instr;
    bus.fx3_mask_value        = exp_mask;
    bus.fx3_thread_idx        = exp_thread;
    bus.fx3_subcycle          = exp_sub;
    for (int l = 0; l < LANES; l++) begin
      bus.fx3_add_significand[l]     = cur[l].add_sig;
      bus.fx3_add_exponent[l]        = cur[l].add_exp;
      bus.fx3_significand_product[l] = cur[l].prod;
      bus.fx3_mul_exponent[l]        = cur[l].mul_exp;
      bus.fx3_result_is_inf[l]       = cur[l].inf;
      bus.fx3_result_is_nan[l]       = cur[l].nan;
      bus.fx3_add_result_sign[l]     = cur[l].add_sign;
      bus.fx3_mul_sign[l]            = cur[l].mul_sign;
    end
  endtask

  task automatic check_lane(input int l, input string tag, input lane_out_t o);
    string p;
    p = $sformatf("%s lane%0d", tag, l);
    check({p, " add_sig"},  64'(bus.fx4_add_significand[l]), 64'(o.add_sig));
    check({p, " add_exp"},  64'(bus.fx4_add_exponent[l]),    64'(o.add_exp));
    check({p, " zero"},     64'(bus.fx4_result_is_zero[l]),  64'(o.zero));
    check({p, " underflow"},64'(bus.fx4_underflow[l]),       64'(o.uf));
    check({p, " inf"},      64'(bus.fx4_result_is_inf[l]),   64'(o.inf));
    check({p, " nan"},      64'(bus.fx4_result_is_nan[l]),   64'(o.nan));
    check({p, " mul_sig"},  64'(bus.fx4_mul_significand[l]), 64'(o.mul_sig));
    check({p, " mul_exp"},  64'(bus.fx4_mul_exponent[l]),    64'(o.mul_exp));
    check({p, " sticky"},   64'(bus.fx4_mul_sticky[l]),      64'(o.sticky));
    check({p, " add_sign"}, 64'(bus.fx4_add_result_sign[l]), 64'(cur[l].add_sign));
    check({p, " mul_sign"}, 64'(bus.fx4_mul_sign[l]),        64'(cur[l].mul_sign));
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, " instruction"}, 64'(bus.fx4_instruction), 64'(exp_instr));
    check({tag, " mask"},        64'(bus.fx4_mask_value),  64'(exp_mask));
    check({tag, " thread"},      64'(bus.fx4_thread_idx),  64'(exp_thread));
    check({tag, " subcycle"},    64'(bus.fx4_subcycle),    64'(exp_sub));
  endtask

  task automatic check_model_lanes(input int first, input string tag);
    for (int l = first; l < LANES; l++) check_lane(l, tag, model(cur_op, cur[l]));
  endtask

  initial begin
    //         op       add_sig       aexp  product                 mexp inf nan | add_sig       aexp z  uf inf nan mul_sig       mexp st
    vecs.push_back(mk(OP_FADD, 32'h0100_0000, 127, 64'h0, 0, 0, 0, 32'h8000_0000, 128, 0, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FSUB, 32'h0040_0000, 127, 64'h0, 0, 0, 0, 32'h8000_0000, 126, 0, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FSUB, 32'h0000_0000, 100, 64'h0, 0, 0, 0, 32'h0,         0,   1, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FADD, 32'h0008_0000, 1,   64'h0, 0, 0, 0, 32'h0,         0,   0, 1, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FADD, 32'h0008_0000, 4,   64'h0, 0, 0, 0, 32'h0,         0,   0, 1, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FADD, 32'h0008_0000, 5,   64'h0, 0, 0, 0, 32'h8000_0000, 1,   0, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FADD, 32'h0100_0000, 254, 64'h0, 0, 0, 0, 32'h8000_0000, 255, 0, 0, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FADD, 32'h0100_0000, 253, 64'h0, 0, 0, 0, 32'h8000_0000, 254, 0, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FADD, 32'h0100_0000, 127, 64'h0, 0, 1, 1, 32'h8000_0000, 128, 0, 0, 1, 1, 32'h0, 0, 0));
    vecs.push_back(mk(OP_ITOF, 32'h0000_0001, 150, 64'h0, 0, 0, 0, 32'h8000_0000, 127, 0, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FTOI, 32'h0000_1234, 150, 64'h0, 0, 0, 0, 32'h0000_1234, 0,   0, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FTOI, 32'h0000_0000, 150, 64'h0, 0, 0, 0, 32'h0,         0,   0, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(OP_FMUL, 32'h0, 0, 64'h0000_9000_0000_0000, 127, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h9000_0000, 128, 0));
    vecs.push_back(mk(OP_FMUL, 32'h0, 0, 64'h0000_4000_0000_0001, 100, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h8000_0000, 100, 1));
    vecs.push_back(mk(OP_FMUL, 32'h0, 0, 64'h0000_8000_0000_0000, 254, 0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h8000_0000, 255, 0));
    vecs.push_back(mk(OP_FMUL, 32'h0, 0, 64'h0000_8000_0000_0000, 253, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h8000_0000, 254, 0));
    vecs.push_back(mk(OP_FMUL, 32'h0, 0, 64'h0000_C000_0000_8000, 50,  0, 0, 32'h0, 0, 0, 0, 0, 0, 32'hC000_0000, 51,  1));

    // Reset with valid asserted at the input: the output valid must stay low.
    reset = 1'b1;
    for (int l = 0; l < LANES; l++) cur[l] = rand_lane();
    drive(1'b1, OP_FADD);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("reset valid", 64'(bus.fx4_instruction_valid), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[v]) begin
      @(negedge clk);
      cur[0] = vecs[v].i;
      for (int l = 1; l < LANES; l++) cur[l] = rand_lane();
      drive(1'b1, vecs[v].op);
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", v), 64'(bus.fx4_instruction_valid), 64'd1);
      check_ctrl($sformatf("vec%0d", v));
      check_lane(0, $sformatf("vec%0d", v), vecs[v].o);
      check_model_lanes(1, $sformatf("vec%0d", v));
    end

    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      for (int l = 0; l < LANES; l++) cur[l] = rand_lane();
      drive(1'b1, alu_op_t'($urandom_range(0, 4)));
      @(posedge clk); #1;
      check_ctrl($sformatf("rand%0d", n));
      check_model_lanes(0, $sformatf("rand%0d", n));
    end

    // Valid 1,1,0,1 with reset on the second cycle; data keeps loading through reset.
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      reset = seq_reset[s];
      for (int l = 0; l < LANES; l++) cur[l] = rand_lane();
      drive(seq_valid[s], alu_op_t'($urandom_range(0, 4)));
      @(posedge clk); #1;
      check($sformatf("seq%0d valid", s), 64'(bus.fx4_instruction_valid), 64'(seq_exp[s]));
      check_ctrl($sformatf("seq%0d", s));
      check_model_lanes(0, $sformatf("seq%0d", s));
    end
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
